// File: rtl/row_clear_engine.sv
// row_clear_engine: multi-cycle line clear for the playfield.
// A start pulse in IDLE captures cur_board. Rows are then scanned bottom-up, one per cycle. Rows
// that are not full are copied down into a separate compaction buffer. Full rows are counted and
// dropped. The vacated top rows are then zeroed, one per cycle. The result is returned on
// nxt_board/num_cleared together with a one-cycle done pulse.
//
// Optional feature macro: ROW_CLEAR_SCORE_EN (adds the 20-bit saturating score output).
//
// Ports:
//   main_clk    in   system clock
//   rst_1plus   in   asynchronous active-high reset
//   start       in   one-cycle request, sampled only in IDLE
//   cur_board   in   board to clear, captured on the accepted start
//   busy        out  high from the cycle after an accepted start through the done cycle
//   done        out  one-cycle pulse; results are valid from this cycle on
//   num_cleared out  rows removed by the last operation
//   nxt_board   out  compacted board
//   score       out  accumulated score (ROW_CLEAR_SCORE_EN only)
module row_clear_engine #(
  parameter int unsigned COLS    = 10,
  parameter int unsigned ROWS    = 20,
  parameter int unsigned CELL_W  = 3,
  parameter int unsigned CNT_W   = 5,
  parameter int unsigned BOARD_W = ROWS * COLS * CELL_W
) (
  input  logic               main_clk,
  input  logic               rst_1plus,
  input  logic               start,
  input  logic [BOARD_W-1:0] cur_board,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   num_cleared,
  output logic [BOARD_W-1:0] nxt_board
`ifdef ROW_CLEAR_SCORE_EN
  ,
  output logic [19:0]        score
`endif
);

  localparam int unsigned ROW_W = COLS * CELL_W;
  localparam int unsigned IDX_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {StIdle, StCompact, StFill, StDone} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] wr_idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ROW_W-1:0] in_q  [ROWS];
  logic [ROW_W-1:0] out_q [ROWS];
  logic             row_full;

  // A row is full when none of its cells is empty.
  always_comb begin
    row_full = 1'b1;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (in_q[rd_idx_q][c*CELL_W +: CELL_W] == '0) row_full = 1'b0;
    end
  end

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      num_cleared <= '0;
      nxt_board   <= '0;
      rd_idx_q    <= '0;
      wr_idx_q    <= '0;
      cnt_q       <= '0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        in_q[r]  <= '0;
        out_q[r] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int unsigned r = 0; r < ROWS; r++) in_q[r] <= cur_board[r*ROW_W +: ROW_W];
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            cnt_q    <= '0;
            busy     <= 1'b1;
            state_q  <= StCompact;
          end
        end
        StCompact: begin
          if (row_full) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            out_q[wr_idx_q] <= in_q[rd_idx_q];
            wr_idx_q        <= wr_idx_q + 1'b1;
          end
          if (rd_idx_q == IDX_W'(ROWS - 1)) begin
            rd_idx_q <= '0;
            if (row_full || cnt_q != '0) begin
              state_q <= StFill;
            end else begin
              // Nothing removed: the compacted buffer is a verbatim copy of the captured board,
              // so results can be registered now without waiting for the last buffer write.
              for (int unsigned r = 0; r < ROWS; r++) nxt_board[r*ROW_W +: ROW_W] <= in_q[r];
              num_cleared <= '0;
              done        <= 1'b1;
              state_q     <= StDone;
            end
          end else begin
            rd_idx_q <= rd_idx_q + 1'b1;
          end
        end
        StFill: begin
          out_q[wr_idx_q] <= '0;
          wr_idx_q        <= wr_idx_q + 1'b1;
          if (wr_idx_q == IDX_W'(ROWS - 1)) begin
            // The top row is being zeroed this cycle; forward that instead of reading it back.
            for (int unsigned r = 0; r < ROWS - 1; r++) nxt_board[r*ROW_W +: ROW_W] <= out_q[r];
            nxt_board[(ROWS-1)*ROW_W +: ROW_W] <= '0;
            num_cleared <= cnt_q;
            done        <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ROW_CLEAR_SCORE_EN
  logic [19:0] rem_pts;
  logic [19:0] score_add;
  logic [20:0] score_sum;

  // 1200 per complete group of four rows, plus the table value for the remainder.
  always_comb begin
    rem_pts = 20'd0;
    unique case (num_cleared[1:0])
      2'd0: rem_pts = 20'd0;
      2'd1: rem_pts = 20'd40;
      2'd2: rem_pts = 20'd100;
      2'd3: rem_pts = 20'd300;
      default: rem_pts = 20'd0;
    endcase
    score_add = 20'(num_cleared >> 2) * 20'd1200 + rem_pts;
    score_sum = {1'b0, score} + {1'b0, score_add};
  end

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      score <= '0;
    end else if (done) begin
      score <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end
  end
`endif

endmodule
